amo_sequencer: RTL
==================

// Module: amo_sequencer
// PURPOSE
//  Sequences one atomic memory operation (AMO/LR/SC) at a time for the load-store unit.
//  Accepts an AMO request, performs the read phase, computes the new value with a single
//  amo_alu instance, performs the write phase and returns the original memory word as rd.
//  Also owns the LR/SC reservation. Sits between LSU issue and the data-memory request port.
// PARAMETERS
//  WIDTH    32  data width; must equal the width of the amo_alu instance
//  ADDR_W   32  address width
//  ID_W     4   request tag width, returned unchanged with the response
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       reset, asynchronous, active-low
//  req_valid      in   1       AMO request valid
//  req_ready      out  1       sequencer can accept a request
//  req_op         in   5       amo_t function code (AMO_*_FN5, LR, SC)
//  req_addr       in   ADDR_W  word-aligned address
//  req_rs2        in   WIDTH   operand / store data
//  req_id         in   ID_W    tag
//  mem_valid      out  1       memory request valid
//  mem_ready      in   1       memory accepts request
//  mem_we         out  1       1 = write, 0 = read
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  WIDTH   write data
//  mem_rvalid     in   1       read data return (one pulse per read)
//  mem_rdata      in   WIDTH   read data
//  snoop_valid    in   1       external write observed (other hart/DMA/plain store)
//  snoop_addr     in   ADDR_W  address of that write
//  rsp_valid      out  1       result valid
//  rsp_ready      in   1       consumer accepts result
//  rsp_rd         out  WIDTH   result written to rd
//  rsp_id         out  ID_W    tag of completed request
// BEHAVIOUR
//  Reset: state IDLE, reservation invalid, req_ready=1, mem_valid=0, rsp_valid=0, rsp_rd=0, rsp_id=0.
//  Handshakes: transfer on valid&ready; valid and payload hold until accepted; no combinational ready->valid paths.
//  FSM: IDLE -> READ (req accepted; op, addr, rs2, id latched) ; IDLE -> SC_CHK for SC.
//   READ: mem_valid=1, mem_we=0; on mem_ready -> WAIT. WAIT: on mem_rvalid latch old=mem_rdata.
//   LR: set reservation {valid=1, addr=req_addr[ADDR_W-1:2]}, rd=old -> RESP.
//   AMO: new=amo_alu(op, old, rs2) registered -> WRITE. WRITE: mem_we=1, mem_wdata=new; on mem_ready -> RESP.
//   SC_CHK (1 cycle): hit = resv valid & addr match; hit -> WRITE with wdata=rs2, rd=0; miss -> RESP, rd=1.
//   Any SC clears the reservation regardless of outcome. RESP: rsp_valid=1; on rsp_ready -> IDLE.
//  req_ready=1 only in IDLE. Uncontended latency (ready/rvalid same-cycle, 1-cycle read return):
//   AMO 5 cycles accept->rsp_valid; LR 3; SC hit 4; SC miss 2.
//  rd for AMOs is the pre-operation memory value, never the ALU output.
//  Reservation: cleared by snoop_valid with matching word address, by own AMO write to the reserved
//   word, and by reset. Snoop and LR set in same cycle, same word: clear wins (LR fails later SC).
//   Snoop during SC_CHK same cycle as check: treated as miss.
//  mem_rvalid outside WAIT is ignored (verification asserts it never occurs).
//  Reset mid-operation: FSM returns to IDLE immediately, outstanding memory transaction abandoned;
//   memory side is reset by the same rst_n.
//  Unsupported op codes: treated as AMO with amo_alu default (X) data; assertion flags them.
// STRUCTURE
//  Shared package: amo_t function codes (incl. LR/SC), FSM state enum amo_seq_state_t.
//  Sub-module: one amo_alu instance (WIDTH passed through); all else in this module.
// TESTING
//  AMOADD addr 0x100, mem=5, rs2=3 -> read 0x100, write 8, rsp_rd=5, 5 cycles latency.
//  AMOMIN mem=0xFFFFFFFF, rs2=1 -> write 0xFFFFFFFF; AMOMINU same -> write 1; both rsp_rd=0xFFFFFFFF.
//  LR 0x200 then SC 0x200 rs2=0xAB -> write 0xAB, rsp_rd=0; second SC 0x200 -> no write, rsp_rd=1.
//  LR 0x200, snoop_valid addr 0x200, SC 0x200 -> rsp_rd=1, no mem write; snoop 0x204 instead -> success.
//  mem_ready low 10 cycles in READ and WRITE, rsp_ready low 5 cycles -> outputs stable, req_ready=0 throughout.
//  rst_n asserted in WAIT -> all outputs at reset values same cycle; next AMO completes correctly.

Source files
------------

// File: rtl/amo_sequencer_pkg.sv
// Shared definitions for the AMO sequencer: function codes, FSM state type
// and state constants, plus a helper that recognises legal op codes.
package amo_sequencer_pkg;

    // Function codes follow the RISC-V A-extension funct5 field.
    typedef enum logic [4:0] {
        AMO_ADD_FN5  = 5'h00,
        AMO_SWAP_FN5 = 5'h01,
        AMO_LR_FN5   = 5'h02,
        AMO_SC_FN5   = 5'h03,
        AMO_XOR_FN5  = 5'h04,
        AMO_OR_FN5   = 5'h08,
        AMO_AND_FN5  = 5'h0C,
        AMO_MIN_FN5  = 5'h10,
        AMO_MAX_FN5  = 5'h14,
        AMO_MINU_FN5 = 5'h18,
        AMO_MAXU_FN5 = 5'h1C
    } amo_t;

    typedef logic [2:0] amo_seq_state_t;

    localparam amo_seq_state_t ST_IDLE   = 3'd0;
    localparam amo_seq_state_t ST_READ   = 3'd1;
    localparam amo_seq_state_t ST_WAIT   = 3'd2;
    localparam amo_seq_state_t ST_CALC   = 3'd3;
    localparam amo_seq_state_t ST_WRITE  = 3'd4;
    localparam amo_seq_state_t ST_SC_CHK = 3'd5;
    localparam amo_seq_state_t ST_RESP   = 3'd6;

    function automatic logic amo_op_supported(input logic [4:0] op);
        case (op)
            AMO_ADD_FN5, AMO_SWAP_FN5, AMO_LR_FN5, AMO_SC_FN5, AMO_XOR_FN5,
            AMO_OR_FN5, AMO_AND_FN5, AMO_MIN_FN5, AMO_MAX_FN5, AMO_MINU_FN5,
            AMO_MAXU_FN5: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amo_sequencer_alu.sv
// Combinational AMO datapath: computes the value written back to memory
// from the original memory word (a) and the register operand (b).
module amo_alu
    import amo_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the read-modify-write result; unknown ops yield X so they stand out.
    always_comb begin
        y = 'x;
        case (op)
            AMO_ADD_FN5:  y = a + b;
            AMO_SWAP_FN5: y = b;
            AMO_XOR_FN5:  y = a ^ b;
            AMO_OR_FN5:   y = a | b;
            AMO_AND_FN5:  y = a & b;
            AMO_MIN_FN5:  y = ($signed(a) < $signed(b)) ? a : b;
            AMO_MAX_FN5:  y = ($signed(a) < $signed(b)) ? b : a;
            AMO_MINU_FN5: y = (a < b) ? a : b;
            AMO_MAXU_FN5: y = (a < b) ? b : a;
            default:      y = 'x;
        endcase
    end

endmodule

// File: rtl/amo_sequencer.sv
// Runs one AMO / LR / SC at a time between LSU issue and the data-memory port,
// and owns the single LR/SC reservation.
// Handshakes: a transfer happens on a cycle where valid and ready are both high;
// valid and payload are held until accepted, and no ready feeds back into a valid
// combinationally (all valids here are decoded from registered state only).
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_rs2,
    input  logic [ID_W-1:0]   req_id,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_rvalid,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rd,
    output logic [ID_W-1:0]   rsp_id,
    output logic [2:0]        dbg_state
);

    amo_seq_state_t      state_q;
    logic [4:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDTH-1:0]    rs2_q;
    logic [ID_W-1:0]     id_q;
    logic [WIDTH-1:0]    rd_q;    // original memory word, or the SC status code
    logic [WIDTH-1:0]    new_q;   // value to be written back
    logic                resv_valid_q;
    logic [ADDR_W-3:0]   resv_word_q;

    logic [WIDTH-1:0]    alu_y;
    logic                snoop_on_resv;
    logic                snoop_on_addr;
    logic                resv_match;
    logic                sc_hit;
    logic                unused_snoop_bits;

    assign unused_snoop_bits = ^snoop_addr[1:0];

    // rd_q holds the pre-operation word, so it is also the ALU's memory operand.
    amo_alu #(.WIDTH(WIDTH)) u_alu (
        .op (op_q),
        .a  (rd_q),
        .b  (rs2_q),
        .y  (alu_y)
    );

    assign snoop_on_resv = snoop_valid && (snoop_addr[ADDR_W-1:2] == resv_word_q);
    assign snoop_on_addr = snoop_valid && (snoop_addr[ADDR_W-1:2] == addr_q[ADDR_W-1:2]);
    assign resv_match    = resv_valid_q && (resv_word_q == addr_q[ADDR_W-1:2]);
    // A snoop landing in the check cycle itself beats the reservation.
    assign sc_hit        = resv_match && !snoop_on_addr;

    // Output decode from registered state only.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        mem_valid = (state_q == ST_READ) || (state_q == ST_WRITE);
        mem_we    = (state_q == ST_WRITE);
        mem_addr  = addr_q;
        mem_wdata = new_q;
        rsp_valid = (state_q == ST_RESP);
        rsp_rd    = rd_q;
        rsp_id    = id_q;
        dbg_state = state_q;
    end

    // Sequencer FSM and request/result datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            rs2_q   <= '0;
            id_q    <= '0;
            rd_q    <= '0;
            new_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        rs2_q   <= req_rs2;
                        id_q    <= req_id;
                        state_q <= (req_op == AMO_SC_FN5) ? ST_SC_CHK : ST_READ;
                    end
                end
                ST_READ: begin
                    if (mem_ready) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rd_q    <= mem_rdata;
                        state_q <= (op_q == AMO_LR_FN5) ? ST_RESP : ST_CALC;
                    end
                end
                ST_CALC: begin
                    // A successful SC stores rs2 unchanged; everything else goes through the ALU.
                    new_q   <= (op_q == AMO_SC_FN5) ? rs2_q : alu_y;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (mem_ready) state_q <= ST_RESP;
                end
                ST_SC_CHK: begin
                    rd_q    <= sc_hit ? '0 : WIDTH'(1);
                    state_q <= sc_hit ? ST_CALC : ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // LR/SC reservation: set by LR data return, dropped by any SC, by a snoop
    // or own write to the reserved word. A snoop hitting the LR word in the
    // same cycle as the set leaves the reservation invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid_q <= 1'b0;
            resv_word_q  <= '0;
        end else if (state_q == ST_WAIT && mem_rvalid && op_q == AMO_LR_FN5) begin
            resv_valid_q <= !snoop_on_addr;
            resv_word_q  <= addr_q[ADDR_W-1:2];
        end else if (state_q == ST_SC_CHK) begin
            resv_valid_q <= 1'b0;
        end else if (snoop_on_resv) begin
            resv_valid_q <= 1'b0;
        end else if (state_q == ST_WRITE && mem_ready && resv_match) begin
            resv_valid_q <= 1'b0;
        end
    end

    // Illegal op codes and stray read returns are caller errors.
    a_op_supported: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && req_ready) |-> amo_op_supported(req_op));
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid |-> (state_q == ST_WAIT));

endmodule
